// File: rtl/game_pkg.sv
// Shared game definitions: FSM encoding, direction and command codes, display geometry.
package game_pkg;

  localparam int unsigned CW       = 12;
  localparam int unsigned D_WIDTH  = 640;
  localparam int unsigned D_HEIGHT = 480;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    PLAY  = 2'd1,
    MISS  = 2'd2
  } state_t;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;
  localparam logic DIR_UP    = 1'b0;
  localparam logic DIR_DOWN  = 1'b1;

  localparam logic [1:0] COM_RIGHT = 2'b01;
  localparam logic [1:0] COM_LEFT  = 2'b10;

  // Horizontal direction chosen by the paddle command; idle/invalid codes keep cur.
  function automatic logic com_dx(input logic [1:0] com, input logic cur);
    case (com)
      COM_RIGHT: return DIR_RIGHT;
      COM_LEFT:  return DIR_LEFT;
      default:   return cur;
    endcase
  endfunction

endpackage

// File: rtl/box_overlap.sv
// Combinational rectangle test of box a against box b (edges inclusive).
module box_overlap #(
  parameter int unsigned W = 12
) (
  input  logic [W-1:0] a_x1,
  input  logic [W-1:0] a_x2,
  input  logic [W-1:0] a_y1,
  input  logic [W-1:0] a_y2,
  input  logic [W-1:0] b_x1,
  input  logic [W-1:0] b_x2,
  input  logic [W-1:0] b_y1,
  input  logic [W-1:0] b_y2,
  output logic         overlap_c,
  output logic         top_cross_c
);

  // Full intersection, plus whether a's top edge is still above b's top edge.
  assign overlap_c   = (a_x2 >= b_x1) && (a_x1 <= b_x2) &&
                       (a_y2 >= b_y1) && (a_y1 <= b_y2);
  assign top_cross_c = (a_y1 < b_y1);

endmodule

// File: rtl/ball_ctrl.sv
// Ball stage: moves the ball per animation step, bounces off walls and paddle, scores hits.
import game_pkg::*;

module ball_ctrl #(
  parameter int unsigned B_SIZE      = 4,
  parameter int unsigned IX          = 320,
  parameter int unsigned IY          = 240,
  parameter int unsigned SPEED       = 2,
  parameter int unsigned D_WIDTH     = game_pkg::D_WIDTH,
  parameter int unsigned D_HEIGHT    = game_pkg::D_HEIGHT,
  parameter int unsigned MISS_FRAMES = 60
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_ani_stb,
  input  logic          i_animate,
  input  logic          i_active,
  input  logic [1:0]    i_com,
  input  logic [CW-1:0] i_px1,
  input  logic [CW-1:0] i_px2,
  input  logic [CW-1:0] i_py1,
  input  logic [CW-1:0] i_py2,
  output logic [CW-1:0] o_x1,
  output logic [CW-1:0] o_x2,
  output logic [CW-1:0] o_y1,
  output logic [CW-1:0] o_y2,
  output logic          o_endgame,
  output logic          o_hit,
  output logic [7:0]    o_score
);

  localparam int unsigned CNT_W = (MISS_FRAMES > 2) ? $clog2(MISS_FRAMES) : 1;

  localparam logic [CW-1:0]    HALF    = CW'(B_SIZE);
  localparam logic [CW-1:0]    SPD     = CW'(SPEED);
  localparam logic [CW-1:0]    X_INIT  = CW'(IX);
  localparam logic [CW-1:0]    Y_INIT  = CW'(IY);
  localparam logic [CW-1:0]    X_LIM   = CW'(D_WIDTH - SPEED);
  localparam logic [CW-1:0]    Y_LIM   = CW'(D_HEIGHT - SPEED);
  localparam logic [CNT_W-1:0] CNT_END = CNT_W'(MISS_FRAMES - 1);

  state_t           state, state_n;
  logic [CW-1:0]    cx, cx_n, cy, cy_n;
  logic             dx, dx_n, dy, dy_n;
  logic [7:0]       score_n;
  logic             hit_n, endgame_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic             step, paddle_ov, paddle_top, paddle_hit;
  logic             dx_w, dy_w;

  assign step    = i_animate & i_ani_stb;
  assign cnt_inc = cnt + 1'b1;

  // Ball edges straight from the centre registers.
  assign o_x1 = cx - HALF;
  assign o_x2 = cx + HALF;
  assign o_y1 = cy - HALF;
  assign o_y2 = cy + HALF;

  box_overlap #(.W(CW)) u_paddle_ov (
    .a_x1        (o_x1),
    .a_x2        (o_x2),
    .a_y1        (o_y1),
    .a_y2        (o_y2),
    .b_x1        (i_px1),
    .b_x2        (i_px2),
    .b_y1        (i_py1),
    .b_y2        (i_py2),
    .overlap_c   (paddle_ov),
    .top_cross_c (paddle_top)
  );

  assign paddle_hit = (dy == DIR_DOWN) && paddle_ov && paddle_top;

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= SERVE;
      cx        <= X_INIT;
      cy        <= Y_INIT;
      dx        <= DIR_RIGHT;
      dy        <= DIR_UP;
      o_score   <= 8'd0;
      o_hit     <= 1'b0;
      o_endgame <= 1'b1;
      cnt       <= '0;
    end else begin
      state     <= state_n;
      cx        <= cx_n;
      cy        <= cy_n;
      dx        <= dx_n;
      dy        <= dy_n;
      o_score   <= score_n;
      o_hit     <= hit_n;
      o_endgame <= endgame_n;
      cnt       <= cnt_n;
    end
  end

  // Next-state: serve/launch, bounce and move, miss hold-off.
  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    dx_n    = dx;
    dy_n    = dy;
    score_n = o_score;
    hit_n   = 1'b0;
    cnt_n   = cnt;
    dx_w    = dx;
    dy_w    = dy;

    case (state)
      SERVE: begin
        cx_n = X_INIT;
        cy_n = Y_INIT;
        if (step) begin
          dx_n = com_dx(i_com, dx);
          if (i_active) begin
            state_n = PLAY;
            score_n = 8'd0;
            dy_n    = DIR_UP;
          end
        end
      end

      PLAY: begin
        if (step) begin
          if ((dx == DIR_LEFT) && (o_x1 <= SPD)) begin
            dx_w = DIR_RIGHT;
          end else if ((dx == DIR_RIGHT) && (o_x2 >= X_LIM)) begin
            dx_w = DIR_LEFT;
          end
          if ((dy == DIR_UP) && (o_y1 <= SPD)) begin
            dy_w = DIR_DOWN;
          end
          if (paddle_hit) begin
            dy_w    = DIR_UP;
            dx_w    = com_dx(i_com, dx_w);
            hit_n   = 1'b1;
            score_n = (o_score == 8'hFF) ? o_score : o_score + 8'd1;
          end
          if ((dy == DIR_DOWN) && !paddle_hit && (o_y2 >= Y_LIM)) begin
            state_n = MISS;
            cnt_n   = '0;
          end else begin
            dx_n = dx_w;
            dy_n = dy_w;
            cx_n = (dx_w == DIR_RIGHT) ? cx + SPD : cx - SPD;
            cy_n = (dy_w == DIR_DOWN)  ? cy + SPD : cy - SPD;
          end
        end
      end

      MISS: begin
        if (step) begin
          if (cnt_inc == CNT_END) begin
            state_n = SERVE;
            cx_n    = X_INIT;
            cy_n    = Y_INIT;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt_inc;
          end
        end
      end

      default: begin
        state_n = SERVE;
      end
    endcase

    endgame_n = (state_n != PLAY);
  end

endmodule

// File: tb/tb_ball_ctrl.sv
// Directed bench for ball_ctrl with a queue-based scoreboard.
module tb_ball_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst, i_ani_stb, i_animate, i_active;
  logic [1:0]  i_com;
  logic [11:0] i_px1, i_px2, i_py1, i_py2;
  logic [11:0] o_x1, o_x2, o_y1, o_y2;
  logic        o_endgame, o_hit;
  logic [7:0]  o_score;

  always #5 i_clk = ~i_clk;

  ball_ctrl dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ani_stb (i_ani_stb),
    .i_animate (i_animate),
    .i_active  (i_active),
    .i_com     (i_com),
    .i_px1     (i_px1),
    .i_px2     (i_px2),
    .i_py1     (i_py1),
    .i_py2     (i_py2),
    .o_x1      (o_x1),
    .o_x2      (o_x2),
    .o_y1      (o_y1),
    .o_y2      (o_y2),
    .o_endgame (o_endgame),
    .o_hit     (o_hit),
    .o_score   (o_score)
  );

  typedef struct {
    string       name;
    logic [11:0] x1, x2, y1, y2;
    logic        eg;
    logic [7:0]  sc;
    logic        hit;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  // Monitor: outputs are presented one edge after each request; compare on the falling edge.
  exp_t e;
  always @(negedge i_clk) begin
    while (q.size() > 0) begin
      e = q.pop_front();
      n_chk++;
      if (o_x1 === e.x1 && o_x2 === e.x2 && o_y1 === e.y1 && o_y2 === e.y2 &&
          o_endgame === e.eg && o_score === e.sc && o_hit === e.hit) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got x=%0d..%0d y=%0d..%0d eg=%0b sc=%0d hit=%0b, want x=%0d..%0d y=%0d..%0d eg=%0b sc=%0d hit=%0b",
                 e.name, o_x1, o_x2, o_y1, o_y2, o_endgame, o_score, o_hit,
                 e.x1, e.x2, e.y1, e.y2, e.eg, e.sc, e.hit);
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic step(input logic act, input logic [1:0] com);
    i_active  = act;
    i_com     = com;
    i_ani_stb = 1'b1;
    i_animate = 1'b1;
    tick();
    i_ani_stb = 1'b0;
    i_animate = 1'b0;
    i_active  = 1'b0;
    i_com     = 2'b00;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 2'b00);
  endtask

  // Push expectation from ball centre (edges are centre +/- 4).
  task automatic expect_st(input string nm, input int cx, input int cy,
                           input logic eg, input int sc, input logic hit);
    exp_t t;
    t.name = nm;
    t.x1 = 12'(cx - 4);
    t.x2 = 12'(cx + 4);
    t.y1 = 12'(cy - 4);
    t.y2 = 12'(cy + 4);
    t.eg = eg;
    t.sc = 8'(sc);
    t.hit = hit;
    q.push_back(t);
  endtask

  task automatic set_paddle(input int x1, input int x2);
    i_px1 = 12'(x1);
    i_px2 = 12'(x2);
    i_py1 = 12'd455;
    i_py2 = 12'd465;
  endtask

  task automatic pulse_reset();
    i_rst     = 1'b1;
    i_ani_stb = 1'b1;
    i_animate = 1'b1;
    i_active  = 1'b1;
    i_com     = 2'b10;
    tick();
    i_rst     = 1'b0;
    i_ani_stb = 1'b0;
    i_animate = 1'b0;
    i_active  = 1'b0;
    i_com     = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    i_rst = 1'b1; i_ani_stb = 1'b0; i_animate = 1'b0; i_active = 1'b0; i_com = 2'b00;
    set_paddle(0, 60);
    tick(); tick();
    i_rst = 1'b0;
    expect_st("reset", 320, 240, 1'b1, 0, 1'b0);
    tick();
    steps(3);
    expect_st("serve_idle", 320, 240, 1'b1, 0, 1'b0);

    // Rally heading right: top wall then right wall.
    step(1'b1, 2'b01);
    expect_st("launch_r", 320, 240, 1'b0, 0, 1'b0);
    steps(1);
    expect_st("first_move", 322, 238, 1'b0, 0, 1'b0);
    steps(116);
    expect_st("top_pre", 554, 6, 1'b0, 0, 1'b0);
    steps(1);
    expect_st("top_flip", 556, 8, 1'b0, 0, 1'b0);
    steps(39);
    expect_st("right_pre", 634, 86, 1'b0, 0, 1'b0);
    steps(1);
    expect_st("right_flip", 632, 88, 1'b0, 0, 1'b0);

    // Reset overrides a concurrent step.
    pulse_reset();
    expect_st("rst_play", 320, 240, 1'b1, 0, 1'b0);

    // Rally heading left: walls, paddle hit, miss, serve.
    set_paddle(340, 400);
    step(1'b1, 2'b10);
    expect_st("launch_l", 320, 240, 1'b0, 0, 1'b0);
    i_ani_stb = 1'b1; i_animate = 1'b0; tick();
    i_ani_stb = 1'b0; i_animate = 1'b1; tick();
    i_animate = 1'b0;
    expect_st("no_animate", 320, 240, 1'b0, 0, 1'b0);
    steps(117);
    expect_st("top_l_pre", 86, 6, 1'b0, 0, 1'b0);
    steps(1);
    expect_st("top_l_flip", 84, 8, 1'b0, 0, 1'b0);
    steps(39);
    expect_st("left_pre", 6, 86, 1'b0, 0, 1'b0);
    steps(1);
    expect_st("left_flip", 8, 88, 1'b0, 0, 1'b0);
    steps(182);
    expect_st("pre_hit", 372, 452, 1'b0, 0, 1'b0);
    step(1'b0, 2'b10);
    expect_st("hit", 370, 450, 1'b0, 1, 1'b1);
    tick();
    expect_st("hit_fall", 370, 450, 1'b0, 1, 1'b0);
    set_paddle(0, 60);
    steps(182);
    expect_st("left2_pre", 6, 86, 1'b0, 1, 1'b0);
    steps(1);
    expect_st("left2_flip", 8, 84, 1'b0, 1, 1'b0);
    steps(40);
    expect_st("top2_flip", 88, 8, 1'b0, 1, 1'b0);
    steps(233);
    expect_st("pre_miss", 554, 474, 1'b0, 1, 1'b0);
    steps(1);
    expect_st("miss", 554, 474, 1'b1, 1, 1'b0);
    steps(58);
    expect_st("miss_hold", 554, 474, 1'b1, 1, 1'b0);
    steps(1);
    expect_st("miss_serve", 320, 240, 1'b1, 1, 1'b0);
    steps(2);
    expect_st("serve_keep", 320, 240, 1'b1, 1, 1'b0);

    // Relaunch with idle command keeps the last dx (right).
    step(1'b1, 2'b00);
    expect_st("relaunch", 320, 240, 1'b0, 0, 1'b0);
    steps(1);
    expect_st("relaunch_mv", 322, 238, 1'b0, 0, 1'b0);
    pulse_reset();
    expect_st("rst_play2", 320, 240, 1'b1, 0, 1'b0);

    tick(); tick();
    if (q.size() != 0) begin
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      n_chk++;
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
